// File: rtl/id_fwd_stage.sv
// Instruction-decode stage: field decode, write-back bypass, multi-depth
// forward-select generation and a load-use interlock feeding the ID/EX register.
module id_fwd_stage #(
  parameter  int DATA_W         = 32,
  parameter  int FWD_DEPTH      = 2,
  parameter  int LOAD_USE_STALL = 1,
  localparam int FS_W           = $clog2(FWD_DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       instr_in,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              flush,
  output logic [4:0]        rs_addr,
  output logic [4:0]        rt_addr,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic              wb_we,
  input  logic [4:0]        wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  output logic              out_valid,
  output logic [5:0]        opcode_out,
  output logic [DATA_W-1:0] imm_out,
  output logic [DATA_W-1:0] val_rs_out,
  output logic [DATA_W-1:0] val_rt_out,
  output logic [4:0]        rwd_out,
  output logic [FS_W-1:0]   rs_fwd,
  output logic [FS_W-1:0]   rt_fwd,
  output logic              rs_ld,
  output logic              rt_ld
);

  typedef enum logic [5:0] {
    OP_RTYPE = 6'h00,
    OP_JUMP  = 6'h02,
    OP_BEQ   = 6'h04,
    OP_LDW   = 6'h23,
    OP_SDW   = 6'h2B,
    OP_STALL = 6'h3F
  } opcode_e;

  logic [5:0]        op;
  logic              is_ldw, is_sdw, is_beq, is_jump, is_bub, is_rtype;
  logic [4:0]        rs, rt, rwd;
  logic              rs_used, rt_used;
  logic [DATA_W-1:0] rs_val, rt_val, imm;
  logic [FS_W-1:0]   rs_sel, rt_sel;
  logic              rs_sel_ld, rt_sel_ld;
  logic              stall, issue;

  logic              hist_v   [1:FWD_DEPTH];
  logic [4:0]        hist_rwd [1:FWD_DEPTH];
  logic              hist_ld  [1:FWD_DEPTH];

  always_comb begin
    op       = instr_in[31:26];
    is_ldw   = (op == OP_LDW);
    is_sdw   = (op == OP_SDW);
    is_beq   = (op == OP_BEQ);
    is_jump  = (op == OP_JUMP);
    is_bub   = (op == OP_STALL);
    is_rtype = (op == OP_RTYPE);
    rs       = instr_in[20:16];
    rt       = (is_sdw || is_beq || is_ldw) ? instr_in[25:21] : instr_in[15:11];
    rwd      = (is_sdw || is_beq || is_jump || is_bub) ? 5'd0 : instr_in[25:21];
    rs_used  = !(is_jump || is_bub);
    rt_used  = is_rtype || is_sdw || is_beq;
    imm      = DATA_W'($signed(instr_in[15:0]));
    rs_val   = (wb_we && wb_addr != 5'd0 && wb_addr == rs) ? wb_data : rs_data;
    rt_val   = (wb_we && wb_addr != 5'd0 && wb_addr == rt) ? wb_data : rt_data;
  end

  // Scan oldest to newest so the nearest matching producer overwrites older ones.
  always_comb begin
    rs_sel    = '0;
    rt_sel    = '0;
    rs_sel_ld = 1'b0;
    rt_sel_ld = 1'b0;
    for (int unsigned k = FWD_DEPTH; k >= 1; k--) begin
      if (rs_used && rs != 5'd0 && hist_v[k] && hist_rwd[k] == rs) begin
        rs_sel    = FS_W'(k);
        rs_sel_ld = hist_ld[k];
      end
      if (rt_used && rt != 5'd0 && hist_v[k] && hist_rwd[k] == rt) begin
        rt_sel    = FS_W'(k);
        rt_sel_ld = hist_ld[k];
      end
    end
  end

  always_comb begin
    stall = (LOAD_USE_STALL != 0) && in_valid && !flush && hist_v[1] && hist_ld[1] &&
            ((rs_used && rs != 5'd0 && hist_rwd[1] == rs) ||
             (rt_used && rt != 5'd0 && hist_rwd[1] == rt));
    issue = in_valid && !flush && !stall;
  end

  assign in_ready = ~stall;
  assign rs_addr  = rs;
  assign rt_addr  = rt;

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      opcode_out <= OP_STALL;
      imm_out    <= '0;
      val_rs_out <= '0;
      val_rt_out <= '0;
      rwd_out    <= '0;
      rs_fwd     <= '0;
      rt_fwd     <= '0;
      rs_ld      <= 1'b0;
      rt_ld      <= 1'b0;
      for (int unsigned k = 1; k <= FWD_DEPTH; k++) begin
        hist_v[k]   <= 1'b0;
        hist_rwd[k] <= '0;
        hist_ld[k]  <= 1'b0;
      end
    end else begin
      hist_v[1]   <= issue && rwd != 5'd0;
      hist_rwd[1] <= rwd;
      hist_ld[1]  <= is_ldw;
      for (int unsigned k = 2; k <= FWD_DEPTH; k++) begin
        hist_v[k]   <= hist_v[k-1];
        hist_rwd[k] <= hist_rwd[k-1];
        hist_ld[k]  <= hist_ld[k-1];
      end
      out_valid <= issue;
      if (issue) begin
        opcode_out <= op;
        imm_out    <= imm;
        val_rs_out <= rs_val;
        val_rt_out <= rt_val;
        rwd_out    <= rwd;
        rs_fwd     <= rs_sel;
        rt_fwd     <= rt_sel;
        rs_ld      <= rs_sel_ld;
        rt_ld      <= rt_sel_ld;
      end else begin
        // Bubble: operand values and immediate keep their last contents.
        opcode_out <= OP_STALL;
        rwd_out    <= '0;
        rs_fwd     <= '0;
        rt_fwd     <= '0;
        rs_ld      <= 1'b0;
        rt_ld      <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_id_fwd_stage.sv
// Directed bench for id_fwd_stage: default build (depth 2, interlock on) and a
// depth-4 build without interlock, checked through a scoreboard queue.
module tb_id_fwd_stage;

  typedef struct packed {
    logic        rdy;
    logic        ov;
    logic [5:0]  op;
    logic [4:0]  rwd;
    logic [2:0]  rsf;
    logic        rsl;
    logic [2:0]  rtf;
    logic        rtl;
    logic [31:0] imm;
    logic [31:0] vrs;
    logic [31:0] vrt;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] instr_a, instr_b;
  logic        valid_a, valid_b, flush_a, flush_b;
  logic        ready_a, ready_b;
  logic [4:0]  rsa_a, rta_a, rsa_b, rta_b;
  logic [31:0] rsd_a, rtd_a, rsd_b, rtd_b;
  logic        wb_we;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        rf_zero;

  logic        ov_a, ov_b, rsl_a, rtl_a, rsl_b, rtl_b;
  logic [5:0]  op_a, op_b;
  logic [31:0] imm_a, imm_b, vrs_a, vrs_b, vrt_a, vrt_b;
  logic [4:0]  rwd_a, rwd_b;
  logic [1:0]  rsf_a, rtf_a;
  logic [2:0]  rsf_b, rtf_b;

  int unsigned checks = 0;
  int unsigned errors = 0;
  exp_t        q[$];
  string       tq[$];
  logic [31:0] last_imm [2];
  logic [31:0] last_vrs [2];
  logic [31:0] last_vrt [2];

  always #5 clk = ~clk;

  always_comb begin
    rsd_a = rf_zero ? 32'h0 : (32'hA000_0000 | {27'h0, rsa_a});
    rtd_a = 32'hB000_0000 | {27'h0, rta_a};
    rsd_b = rf_zero ? 32'h0 : (32'hA000_0000 | {27'h0, rsa_b});
    rtd_b = 32'hB000_0000 | {27'h0, rta_b};
  end

  id_fwd_stage dut_a (
    .clk(clk), .rst(rst), .instr_in(instr_a), .in_valid(valid_a), .in_ready(ready_a),
    .flush(flush_a), .rs_addr(rsa_a), .rt_addr(rta_a), .rs_data(rsd_a), .rt_data(rtd_a),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .out_valid(ov_a),
    .opcode_out(op_a), .imm_out(imm_a), .val_rs_out(vrs_a), .val_rt_out(vrt_a),
    .rwd_out(rwd_a), .rs_fwd(rsf_a), .rt_fwd(rtf_a), .rs_ld(rsl_a), .rt_ld(rtl_a)
  );

  id_fwd_stage #(.DATA_W(32), .FWD_DEPTH(4), .LOAD_USE_STALL(0)) dut_b (
    .clk(clk), .rst(rst), .instr_in(instr_b), .in_valid(valid_b), .in_ready(ready_b),
    .flush(flush_b), .rs_addr(rsa_b), .rt_addr(rta_b), .rs_data(rsd_b), .rt_data(rtd_b),
    .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data), .out_valid(ov_b),
    .opcode_out(op_b), .imm_out(imm_b), .val_rs_out(vrs_b), .val_rt_out(vrt_b),
    .rwd_out(rwd_b), .rs_fwd(rsf_b), .rt_fwd(rtf_b), .rs_ld(rsl_b), .rt_ld(rtl_b)
  );

  function automatic logic [31:0] radd(input logic [4:0] d, input logic [4:0] s, input logic [4:0] t);
    return {6'h00, d, s, t, 11'h0};
  endfunction

  function automatic logic [31:0] ldw(input logic [4:0] d, input logic [4:0] s);
    return {6'h23, d, s, 16'h0004};
  endfunction

  function automatic logic [31:0] rv(input logic [4:0] r);
    return 32'hA000_0000 | {27'h0, r};
  endfunction

  function automatic logic [31:0] tv(input logic [4:0] r);
    return 32'hB000_0000 | {27'h0, r};
  endfunction

  function automatic exp_t bub(input logic rdy);
    exp_t e;
    e     = '0;
    e.rdy = rdy;
    e.op  = 6'h3F;
    return e;
  endfunction

  function automatic exp_t iss(input logic [5:0] op, input logic [4:0] rwd,
                               input logic [2:0] rsf, input logic rsl,
                               input logic [2:0] rtf, input logic rtl,
                               input logic [31:0] vrs, input logic [31:0] vrt);
    exp_t e;
    e     = '0;
    e.rdy = 1'b1;
    e.ov  = 1'b1;
    e.op  = op;
    e.rwd = rwd;
    e.rsf = rsf;
    e.rsl = rsl;
    e.rtf = rtf;
    e.rtl = rtl;
    e.vrs = vrs;
    e.vrt = vrt;
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
      else begin
        errors++;
        $error("FAIL %s observed %h expected %h", tag, obs, exp);
      end
  endtask

  task automatic step(input string tag, input bit b, input logic [31:0] ins,
                      input bit v, input bit fl, input bit r, input exp_t e_in);
    exp_t e;
    exp_t x;
    string t;
    e = e_in;
    instr_a = b ? 32'h0 : ins;
    valid_a = b ? 1'b0 : v;
    flush_a = b ? 1'b0 : fl;
    instr_b = b ? ins : 32'h0;
    valid_b = b ? v : 1'b0;
    flush_b = b ? fl : 1'b0;
    rst     = r;
    #1;
    chk({tag, "/in_ready"}, 32'(b ? ready_b : ready_a), 32'(e.rdy));
    if (r) begin
      e.imm = '0; e.vrs = '0; e.vrt = '0;
      for (int i = 0; i < 2; i++) begin
        last_imm[i] = '0; last_vrs[i] = '0; last_vrt[i] = '0;
      end
    end else if (e.ov) begin
      e.imm = {{16{ins[15]}}, ins[15:0]};
      last_imm[b] = e.imm; last_vrs[b] = e.vrs; last_vrt[b] = e.vrt;
    end else begin
      e.imm = last_imm[b]; e.vrs = last_vrs[b]; e.vrt = last_vrt[b];
    end
    q.push_back(e);
    tq.push_back(tag);
    @(posedge clk);
    #1;
    rst = 1'b0;
    x = q.pop_front();
    t = tq.pop_front();
    chk({t, "/out_valid"}, 32'(b ? ov_b : ov_a), 32'(x.ov));
    chk({t, "/opcode"},    32'(b ? op_b : op_a), 32'(x.op));
    chk({t, "/rwd"},       32'(b ? rwd_b : rwd_a), 32'(x.rwd));
    chk({t, "/rs_fwd"},    b ? 32'(rsf_b) : 32'(rsf_a), 32'(x.rsf));
    chk({t, "/rt_fwd"},    b ? 32'(rtf_b) : 32'(rtf_a), 32'(x.rtf));
    chk({t, "/rs_ld"},     32'(b ? rsl_b : rsl_a), 32'(x.rsl));
    chk({t, "/rt_ld"},     32'(b ? rtl_b : rtl_a), 32'(x.rtl));
    chk({t, "/imm"},       b ? imm_b : imm_a, x.imm);
    chk({t, "/val_rs"},    b ? vrs_b : vrs_a, x.vrs);
    chk({t, "/val_rt"},    b ? vrt_b : vrt_a, x.vrt);
  endtask

  task automatic idle(input string tag, input bit b, input int n);
    for (int i = 0; i < n; i++) step(tag, b, 32'h0, 1'b0, 1'b0, 1'b0, bub(1'b1));
  endtask

  task automatic go(input string tag, input bit b, input logic [31:0] ins, input exp_t e);
    step(tag, b, ins, 1'b1, 1'b0, 1'b0, e);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired before the sequence completed");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    instr_a = '0; instr_b = '0;
    valid_a = 1'b0; valid_b = 1'b0; flush_a = 1'b0; flush_b = 1'b0;
    wb_we = 1'b0; wb_addr = '0; wb_data = '0; rf_zero = 1'b0;
    for (int i = 0; i < 2; i++) begin
      last_imm[i] = '0; last_vrs[i] = '0; last_vrt[i] = '0;
    end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    idle("reset_idle", 1'b0, 3);
    idle("reset_idle_b", 1'b1, 1);

    go("add_r3",  1'b0, radd(3, 1, 2),  iss(6'h00, 3, 0, 0, 0, 0, rv(1), tv(2)));
    go("fwd1",    1'b0, radd(6, 3, 2),  iss(6'h00, 6, 1, 0, 0, 0, rv(3), tv(2)));
    go("re_r3",   1'b0, radd(3, 1, 2),  iss(6'h00, 3, 0, 0, 0, 0, rv(1), tv(2)));
    go("unrel",   1'b0, radd(10, 1, 2), iss(6'h00, 10, 0, 0, 0, 0, rv(1), tv(2)));
    go("fwd2",    1'b0, radd(11, 3, 1), iss(6'h00, 11, 2, 0, 0, 0, rv(3), tv(1)));
    idle("gap", 1'b0, 2);

    go("ldw_r5",   1'b0, ldw(5, 1),      iss(6'h23, 5, 0, 0, 0, 0, rv(1), tv(5)));
    go("lu_stall", 1'b0, radd(12, 1, 5), bub(1'b0));
    go("lu_issue", 1'b0, radd(12, 1, 5), iss(6'h00, 12, 0, 0, 2, 1, rv(1), tv(5)));
    idle("gap", 1'b0, 2);

    go("ll_ld1",    1'b0, ldw(5, 1),      iss(6'h23, 5, 0, 0, 0, 0, rv(1), tv(5)));
    go("ll_stall1", 1'b0, ldw(6, 5),      bub(1'b0));
    go("ll_ld2",    1'b0, ldw(6, 5),      iss(6'h23, 6, 2, 1, 0, 0, rv(5), tv(6)));
    go("ll_stall2", 1'b0, radd(15, 6, 1), bub(1'b0));
    go("ll_use",    1'b0, radd(15, 6, 1), iss(6'h00, 15, 2, 1, 0, 0, rv(6), tv(1)));
    idle("gap", 1'b0, 2);

    wb_we = 1'b1; wb_addr = 5'd7; wb_data = 32'hDEAD_BEEF; rf_zero = 1'b1;
    go("wb_byp", 1'b0, radd(13, 7, 1), iss(6'h00, 13, 0, 0, 0, 0, 32'hDEAD_BEEF, tv(1)));
    rf_zero = 1'b0; wb_addr = 5'd0;
    go("wb_r0",  1'b0, radd(13, 0, 1), iss(6'h00, 13, 0, 0, 0, 0, rv(0), tv(1)));
    wb_addr = 5'd1;
    go("wb_rt",  1'b0, radd(14, 2, 1), iss(6'h00, 14, 0, 0, 0, 0, rv(2), 32'hDEAD_BEEF));
    wb_we = 1'b0;
    idle("gap", 1'b0, 2);

    go("prod_r4", 1'b0, radd(4, 1, 2), iss(6'h00, 4, 0, 0, 0, 0, rv(1), tv(2)));
    step("flush", 1'b0, radd(4, 1, 2), 1'b1, 1'b1, 1'b0, bub(1'b1));
    go("fl_fwd2", 1'b0, radd(14, 4, 1), iss(6'h00, 14, 2, 0, 0, 0, rv(4), tv(1)));
    idle("gap", 1'b0, 2);

    go("fs_ldw", 1'b0, ldw(5, 1), iss(6'h23, 5, 0, 0, 0, 0, rv(1), tv(5)));
    step("fl_over_stall", 1'b0, radd(12, 1, 5), 1'b1, 1'b1, 1'b0, bub(1'b1));
    go("after_fl", 1'b0, radd(12, 1, 5), iss(6'h00, 12, 0, 0, 2, 1, rv(1), tv(5)));
    idle("gap", 1'b0, 2);

    go("rs_ldw", 1'b0, ldw(5, 1), iss(6'h23, 5, 0, 0, 0, 0, rv(1), tv(5)));
    step("rst_in_stall", 1'b0, radd(12, 1, 5), 1'b1, 1'b0, 1'b1, bub(1'b0));
    go("re_present", 1'b0, radd(12, 1, 5), iss(6'h00, 12, 0, 0, 0, 0, rv(1), tv(5)));

    go("sext", 1'b0, radd(16, 1, 17), iss(6'h00, 16, 0, 0, 0, 0, rv(1), tv(17)));
    go("jump", 1'b0, {6'h02, 5'd16, 5'd16, 16'h0000}, iss(6'h02, 0, 0, 0, 0, 0, rv(16), tv(0)));
    go("sdw",  1'b0, {6'h2B, 5'd16, 5'd1, 16'h0008},  iss(6'h2B, 0, 0, 0, 2, 0, rv(1), tv(16)));
    idle("gap", 1'b0, 2);

    go("b_ldw",     1'b1, ldw(5, 1),      iss(6'h23, 5, 0, 0, 0, 0, rv(1), tv(5)));
    go("b_nostall", 1'b1, radd(16, 1, 5), iss(6'h00, 16, 0, 0, 1, 1, rv(1), tv(5)));
    idle("gap_b", 1'b1, 4);

    go("b_p9a",   1'b1, radd(9, 1, 2),  iss(6'h00, 9, 0, 0, 0, 0, rv(1), tv(2)));
    go("b_p20",   1'b1, radd(20, 1, 2), iss(6'h00, 20, 0, 0, 0, 0, rv(1), tv(2)));
    go("b_p9b",   1'b1, radd(9, 1, 2),  iss(6'h00, 9, 0, 0, 0, 0, rv(1), tv(2)));
    go("b_near",  1'b1, radd(21, 9, 1), iss(6'h00, 21, 1, 0, 0, 0, rv(9), tv(1)));
    idle("gap_b", 1'b1, 4);

    go("b_p9",    1'b1, radd(9, 1, 2),  iss(6'h00, 9, 0, 0, 0, 0, rv(1), tv(2)));
    go("b_p22",   1'b1, radd(22, 1, 2), iss(6'h00, 22, 0, 0, 0, 0, rv(1), tv(2)));
    go("b_p23",   1'b1, radd(23, 1, 2), iss(6'h00, 23, 0, 0, 0, 0, rv(1), tv(2)));
    go("b_p24",   1'b1, radd(24, 1, 2), iss(6'h00, 24, 0, 0, 0, 0, rv(1), tv(2)));
    go("b_fwd4",  1'b1, radd(25, 9, 1), iss(6'h00, 25, 4, 0, 0, 0, rv(9), tv(1)));
    go("b_fwd5",  1'b1, radd(26, 9, 1), iss(6'h00, 26, 0, 0, 0, 0, rv(9), tv(1)));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
